// File: rtl/parity_accumulator_framed_pkg.sv
// Shared definitions for the framed multi-lane parity accumulator:
// FSM encodings, default sizing and the lane slice helper.
package parity_accumulator_framed_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam int unsigned DEF_M     = 16;
  localparam int unsigned DEF_NCH   = 4;
  localparam int unsigned DEF_LEN_W = 8;

  // Low bit index of lane c inside a packed NCH*M word.
  function automatic int unsigned lane_lo(input int unsigned c, input int unsigned m);
    return c * m;
  endfunction

endpackage

// File: rtl/parity_accumulator_framed_if.sv
// Beat-in / parity-out handshake bundle for parity_accumulator_framed.
// master drives beats and consumes parity; slave is the accumulator.
interface parity_accumulator_framed_if
  import parity_accumulator_framed_pkg::*;
#(
  parameter int unsigned M     = DEF_M,
  parameter int unsigned NCH   = DEF_NCH,
  parameter int unsigned LEN_W = DEF_LEN_W
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sof;
  logic [NCH*M-1:0]     in_data;
  logic [NCH-1:0]       ch_en;
  logic [LEN_W-1:0]     frame_len;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*M-1:0]     out_parity;
  logic [LEN_W-1:0]     out_beats;
  logic                 err_pulse;

  modport master (
    output in_valid, in_sof, in_data, ch_en, frame_len, out_ready,
    input  in_ready, out_valid, out_parity, out_beats, err_pulse
  );

  modport slave (
    input  in_valid, in_sof, in_data, ch_en, frame_len, out_ready,
    output in_ready, out_valid, out_parity, out_beats, err_pulse
  );

endinterface

// File: rtl/parity_accumulator_framed_lane.sv
// One M-bit XOR parity lane with load / accumulate / clear controls.
module parity_acc_lane #(
  parameter int unsigned M = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_acc,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [M-1:0] i_d,
  output logic [M-1:0] o_q
);

  logic [M-1:0] r_acc;
  logic [M-1:0] w_d;

  assign w_d = i_d & {M{i_en}};
  assign o_q = r_acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= w_d;
    end else if (i_acc) begin
      r_acc <= r_acc ^ w_d;
    end
  end

endmodule

// File: rtl/parity_accumulator_framed.sv
// Frame-aware NCH-lane parity XOR accumulator: collects frame_len beats,
// then holds the parity word until the downstream handshake.
module parity_accumulator_framed
  import parity_accumulator_framed_pkg::*;
#(
  parameter int unsigned M     = DEF_M,
  parameter int unsigned NCH   = DEF_NCH,
  parameter int unsigned LEN_W = DEF_LEN_W
) (
  input  logic                        clk,
  input  logic                        rst,
  parity_accumulator_framed_if.slave  bus
);

  logic [1:0]       r_state;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] r_len;
  logic [NCH-1:0]   r_en;
  logic             r_err;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_sof;
  logic             w_beat;
  logic             w_stray;
  logic             w_take;
  logic [LEN_W-1:0] w_len_eff;
  logic [LEN_W-1:0] w_cnt_inc;
  logic [NCH*M-1:0] w_in_data;
  logic [NCH*M-1:0] w_parity;

  assign w_in_ready = (r_state != S_OUT);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_sof      = w_accept && bus.in_sof;
  assign w_beat     = w_accept && !bus.in_sof && (r_state == S_ACC);
  assign w_take     = (r_state == S_OUT) && bus.out_ready;
  assign w_len_eff  = (bus.frame_len == '0) ? LEN_W'(1) : bus.frame_len;
  assign w_cnt_inc  = r_count + LEN_W'(1);
  assign w_in_data  = bus.in_data;

  // A non-SOF beat in IDLE and an SOF beat mid-frame are both protocol errors;
  // the SOF case still restarts the frame below.
  assign w_stray = w_accept &&
                   (((r_state == S_IDLE) && !bus.in_sof) ||
                    ((r_state == S_ACC)  &&  bus.in_sof));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_len   <= '0;
      r_en    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_stray;
      if (w_sof) begin
        r_len   <= w_len_eff;
        r_en    <= bus.ch_en;
        r_count <= LEN_W'(1);
        r_state <= (w_len_eff == LEN_W'(1)) ? S_OUT : S_ACC;
      end else if (w_beat) begin
        r_count <= w_cnt_inc;
        if (w_cnt_inc == r_len) begin
          r_state <= S_OUT;
        end
      end else if (w_take) begin
        r_count <= '0;
        r_state <= S_IDLE;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    localparam int unsigned LO = lane_lo(c, M);

    parity_acc_lane #(.M(M)) u_lane (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_load  (w_sof),
      .i_acc   (w_beat),
      .i_clr   (w_take),
      .i_en    (w_sof ? bus.ch_en[c] : r_en[c]),
      .i_d     (w_in_data[LO +: M]),
      .o_q     (w_parity[LO +: M])
    );
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_state == S_OUT);
  assign bus.out_parity = w_parity;
  assign bus.out_beats  = r_count;
  assign bus.err_pulse  = r_err;

endmodule
